// File: rtl/pls_tx_nway.sv
// 10BASE-T PLS transmitter: Manchester data path, IDL delimiter, post-frame silence,
// and NLP / FLP link integrity signalling with registered line outputs.
module pls_tx_nway #(
   parameter int unsigned LINK_PERIOD    = 320000,
   parameter int unsigned LP_WIDTH       = 2,
   parameter int unsigned FLP_SLOT       = 1250,
   parameter int unsigned IDL_CYCLES     = 12,
   parameter int unsigned SILENCE_CYCLES = 48
) (
   input  logic        clk_20mhz,
   input  logic        rst_i,
   input  logic        data_enable,
   input  logic        txd_in,
   input  logic        flp_enable,
   input  logic [15:0] link_code_word,
   output logic        txd_out_p,
   output logic        txd_out_n,
   output logic        txbusy,
   output logic        pulse_active
);

   localparam int unsigned TW   = $clog2(LINK_PERIOD + 1);
   localparam int unsigned M1   = (FLP_SLOT > LP_WIDTH) ? FLP_SLOT : LP_WIDTH;
   localparam int unsigned M2   = (IDL_CYCLES > SILENCE_CYCLES) ? IDL_CYCLES : SILENCE_CYCLES;
   localparam int unsigned CMAX = (M1 > M2) ? M1 : M2;
   localparam int unsigned CW   = $clog2(CMAX + 1);
   localparam logic [5:0]  LastSlot = 6'd32;

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StH1      = 3'd1;
   localparam logic [2:0] StH2      = 3'd2;
   localparam logic [2:0] StIdl     = 3'd3;
   localparam logic [2:0] StSilence = 3'd4;
   localparam logic [2:0] StLink    = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d, timer_inc;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [5:0]    slot_q, slot_d;
   logic [15:0]   code_q, code_d;
   logic          flp_q, flp_d;
   logic          bit_q, bit_d;
   logic          p_q, p_d, n_q, n_d, busy_q, busy_d, pa_q, pa_d;

   // Even slots carry clock pulses; odd slot 2i+1 carries code word bit i.
   function automatic logic slot_pulse(input logic [5:0] s, input logic [15:0] cw);
      return (s[0] == 1'b0) ? 1'b1 : cw[s[4:1]];
   endfunction

   // Saturating so an overlong burst cannot wrap the timer and skip the next expiry.
   assign timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + TW'(1);

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      cnt_d   = cnt_q;
      slot_d  = slot_q;
      code_d  = code_q;
      flp_d   = flp_q;
      bit_d   = bit_q;
      p_d     = 1'b0;
      n_d     = 1'b0;
      case (state_q)
         StIdle: begin
            if (data_enable) begin
               state_d = StH1;
               timer_d = '0;
               bit_d   = txd_in;
               p_d     = ~txd_in;
               n_d     = txd_in;
            end else if (timer_q >= TW'(LINK_PERIOD - 1)) begin
               state_d = StLink;
               timer_d = '0;
               flp_d   = flp_enable;
               code_d  = link_code_word;
               slot_d  = '0;
               cnt_d   = '0;
               p_d     = 1'b1;
            end else begin
               timer_d = timer_inc;
            end
         end
         StH1: begin
            state_d = StH2;
            p_d     = bit_q;
            n_d     = ~bit_q;
         end
         StH2: begin
            if (data_enable) begin
               state_d = StH1;
               bit_d   = txd_in;
               p_d     = ~txd_in;
               n_d     = txd_in;
            end else begin
               state_d = StIdl;
               cnt_d   = '0;
               p_d     = 1'b1;
            end
         end
         StIdl: begin
            if (cnt_q == CW'(IDL_CYCLES - 1)) begin
               state_d = StSilence;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
               p_d   = 1'b1;
            end
         end
         StSilence: begin
            timer_d = timer_inc;
            if (cnt_q == CW'(SILENCE_CYCLES - 1)) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StLink: begin
            timer_d = timer_inc;
            if (!flp_q) begin
               if (cnt_q == CW'(LP_WIDTH - 1)) begin
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q + CW'(1);
                  p_d   = 1'b1;
               end
            end else if (slot_q == LastSlot && cnt_q == CW'(LP_WIDTH - 1)) begin
               state_d = StIdle;
            end else if (cnt_q == CW'(FLP_SLOT - 1)) begin
               cnt_d  = '0;
               slot_d = slot_q + 6'd1;
               p_d    = slot_pulse(slot_q + 6'd1, code_q);
            end else begin
               cnt_d = cnt_q + CW'(1);
               p_d   = (cnt_q + CW'(1) < CW'(LP_WIDTH)) && slot_pulse(slot_q, code_q);
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
      pa_d   = (state_d == StLink);
   end

   always_ff @(posedge clk_20mhz or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         timer_q <= '0;
         cnt_q   <= '0;
         slot_q  <= '0;
         code_q  <= '0;
         flp_q   <= 1'b0;
         bit_q   <= 1'b0;
         p_q     <= 1'b0;
         n_q     <= 1'b0;
         busy_q  <= 1'b0;
         pa_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         slot_q  <= slot_d;
         code_q  <= code_d;
         flp_q   <= flp_d;
         bit_q   <= bit_d;
         p_q     <= p_d;
         n_q     <= n_d;
         busy_q  <= busy_d;
         pa_q    <= pa_d;
      end
   end

   assign txd_out_p    = p_q;
   assign txd_out_n    = n_q;
   assign txbusy       = busy_q;
   assign pulse_active = pa_q;

endmodule

// File: tb/tb_pls_tx_nway.sv
// Directed bench for pls_tx_nway: per-cycle expected line states are queued as stimulus
// is planned and popped against {p, n, txbusy, pulse_active} one cycle at a time.
module tb_pls_tx_nway;

   localparam logic [3:0] EIdle   = 4'b0000;
   localparam logic [3:0] EPulse  = 4'b1011;
   localparam logic [3:0] EIdl    = 4'b1010;
   localparam logic [3:0] ESil    = 4'b0010;
   localparam logic [3:0] EBurst0 = 4'b0011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        de = 1'b0;
   logic        txd = 1'b0;
   logic        flp = 1'b0;
   logic [15:0] code = 16'h0000;
   logic        p, n, busy, pa;

   int          checks = 0;
   int          passes = 0;
   int          pulses = 0;
   int          cyc = 0;
   bit          count_en = 1'b0;
   logic        prev_p = 1'b0;
   logic [3:0]  q[$];

   always #5 clk = ~clk;

   pls_tx_nway #(
      .LINK_PERIOD   (64),
      .LP_WIDTH      (2),
      .FLP_SLOT      (8),
      .IDL_CYCLES    (12),
      .SILENCE_CYCLES(48)
   ) dut (
      .clk_20mhz     (clk),
      .rst_i         (rst),
      .data_enable   (de),
      .txd_in        (txd),
      .flp_enable    (flp),
      .link_code_word(code),
      .txd_out_p     (p),
      .txd_out_n     (n),
      .txbusy        (busy),
      .pulse_active  (pa)
   );

   task automatic check(input string tag, input logic [3:0] exp);
      logic [3:0] obs;
      obs = {p, n, busy, pa};
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s cycle %0d observed {p,n,busy,pa}=%b expected=%b", tag, cyc, obs, exp);
   endtask

   task automatic push(input int num, input logic [3:0] v);
      repeat (num) q.push_back(v);
   endtask

   task automatic run(input int num, input string tag);
      for (int i = 0; i < num; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (count_en && p && !prev_p) pulses++;
         prev_p = p;
         if (q.size() == 0) begin
            checks++;
            $error("FAIL %s cycle %0d observed scoreboard empty expected queued entry", tag, cyc);
         end else begin
            check(tag, q.pop_front());
         end
      end
   endtask

   // Called at 1 time unit after an edge: asserts reset mid-cycle, checks outputs before any
   // further edge, then releases just after the next edge (that edge's successor is cycle 1).
   task automatic do_reset(input string tag);
      #3;
      rst = 1'b1;
      #1;
      check(tag, EIdle);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      prev_p = 1'b0;
   endtask

   initial begin
      int          bits[4];
      logic        b;
      logic        v;
      logic [15:0] code_exp;
      bits = '{1, 0, 1, 1};

      @(posedge clk);
      #1;
      do_reset("reset_initial");

      // NLP every 64 cycles, first at cycle 64
      push(63, EIdle); push(2, EPulse); push(62, EIdle); push(2, EPulse); push(1, EIdle);
      run(130, "nlp_period");

      // Frame 1,0,1,1 then IDL, silence; timer frozen during data and IDL
      do_reset("reset_frame");
      for (int i = 0; i < 4; i++) begin
         b   = bits[i][0];
         de  = 1'b1;
         txd = b;
         push(1, {~b, b, 2'b10});
         push(1, {b, ~b, 2'b10});
         run(2, "frame_bits");
      end
      de = 1'b0;
      push(12, EIdl); push(48, ESil); push(16, EIdle); push(2, EPulse);
      run(78, "frame_tail");

      // FLP burst with code word 8001, inputs disturbed mid-burst
      do_reset("reset_flp");
      flp  = 1'b1;
      code = 16'h8001;
      code_exp = 16'h8001;
      push(63, EIdle);
      run(63, "flp_wait");
      for (int s = 0; s <= 32; s++) begin
         v = (s % 2 == 0) ? 1'b1 : code_exp[(s - 1) / 2];
         push(2, {v, 1'b0, 2'b11});
         if (s < 32) push(6, EBurst0);
      end
      count_en = 1'b1;
      run(40, "flp_burst");
      code = 16'h0000;
      flp  = 1'b0;
      run(100, "flp_burst_changed");
      de  = 1'b1;
      txd = 1'b1;
      run(118, "flp_burst_de_ignored");
      count_en = 1'b0;
      checks++;
      assert (pulses == 19) passes++;
      else $error("FAIL flp_pulse_count observed %0d expected 19", pulses);

      // Held data_enable starts a frame only once back in IDLE
      push(1, EIdle); push(1, 4'b0110); push(1, 4'b1010);
      run(3, "frame_after_burst");
      de = 1'b0;
      push(12, EIdl); push(48, ESil);
      run(32, "silence_plain");
      de  = 1'b1;
      txd = 1'b0;
      run(28, "silence_de_ignored");
      push(1, EIdle); push(1, 4'b1010); push(1, 4'b0110);
      run(3, "frame_after_silence");
      de = 1'b0;
      push(1, EIdl);
      run(1, "frame_after_silence_idl");

      // Data on the exact expiry cycle wins; no pulse
      do_reset("reset_collide");
      push(63, EIdle);
      run(63, "collide_wait");
      de  = 1'b1;
      txd = 1'b0;
      push(1, 4'b1010);
      run(1, "collide_start");
      de = 1'b0;
      push(1, 4'b0110); push(12, EIdl); push(48, ESil); push(16, EIdle); push(2, EPulse);
      run(79, "collide_tail");

      // Async reset mid-frame and mid-burst
      do_reset("reset_pre_frame");
      de  = 1'b1;
      txd = 1'b1;
      push(1, 4'b0110); push(1, 4'b1010);
      run(2, "abort_frame");
      de = 1'b0;
      do_reset("reset_mid_frame");
      flp  = 1'b1;
      code = 16'hFFFF;
      push(63, EIdle); push(2, EPulse); push(3, EBurst0);
      run(68, "abort_burst");
      do_reset("reset_mid_burst");
      flp = 1'b0;
      push(63, EIdle); push(2, EPulse); push(1, EIdle);
      run(66, "after_abort");

      checks++;
      assert (q.size() == 0) passes++;
      else $error("FAIL scoreboard_drain observed %0d left expected 0", q.size());

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
